cbps_seq: RTL

CBPS_SEQ -- requirements
Module: cbps_seq

---
 rtl/cbps_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cbps_seq.sv
// Sequential carry-bypass subtractor: processes one BLK-bit block per cycle, LSB block first.
// Optional macro CBPS_ADD_MODE_EN adds a 'sub' input selecting add (sub=0) or subtract (sub=1).
module cbps_seq #(
    parameter int N   = 32,
    parameter int BLK = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               R,
    input  logic [N-1:0]               T,
`ifdef CBPS_ADD_MODE_EN
    input  logic                       sub,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               diff,
    output logic                       cout,
    output logic                       OF,
    output logic [$clog2(N/BLK):0]     skip_cnt
);

    localparam int NB = N / BLK;
    localparam int IW = $clog2(NB);
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    logic [N-1:0]   r_r;
    logic [N-1:0]   r_teff;
    logic [IW-1:0]  r_idx;
    logic           r_carry;

    logic [N-1:0]   w_teff_in;
    logic           w_cin;
    logic [BLK-1:0] w_r_blk;
    logic [BLK-1:0] w_t_blk;
    logic [BLK-1:0] w_p;
    logic [BLK-1:0] w_sum;
    logic           w_ripple_c;
    logic           w_bypass;
    logic           w_blk_cout;
    logic           w_last;

`ifdef CBPS_ADD_MODE_EN
    assign w_teff_in = sub ? ~T : T;
    assign w_cin     = sub;
`else
    assign w_teff_in = ~T;
    assign w_cin     = 1'b1;
`endif

    assign w_r_blk = r_r[r_idx*BLK +: BLK];
    assign w_t_blk = r_teff[r_idx*BLK +: BLK];
    assign w_p     = w_r_blk ^ w_t_blk;
    assign w_last  = (r_idx == IW'(NB - 1));

    always_comb begin
        w_sum      = '0;
        w_ripple_c = r_carry;
        for (int unsigned i = 0; i < BLK; i++) begin
            w_sum[i]   = w_p[i] ^ w_ripple_c;
            w_ripple_c = (w_r_blk[i] & w_t_blk[i]) | (w_ripple_c & w_p[i]);
        end
    end

    // A fully propagating block passes its carry-in straight through.
    assign w_bypass   = &w_p;
    assign w_blk_cout = w_bypass ? r_carry : w_ripple_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            cout      <= 1'b0;
            OF        <= 1'b0;
            skip_cnt  <= '0;
            r_r       <= '0;
            r_teff    <= '0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_r      <= R;
                        r_teff   <= w_teff_in;
                        r_carry  <= w_cin;
                        r_idx    <= '0;
                        skip_cnt <= '0;
                        diff     <= '0;
                        in_ready <= 1'b0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    diff[r_idx*BLK +: BLK] <= w_sum;
                    r_carry <= w_blk_cout;
                    r_idx   <= r_idx + IW'(1);
                    if (w_bypass)
                        skip_cnt <= skip_cnt + SW'(1);
                    // Flags come from the MSB block sum, which lands in diff on this same edge.
                    if (w_last) begin
                        cout      <= w_blk_cout;
                        OF        <= ~(r_r[N-1] ^ r_teff[N-1]) & (w_sum[BLK-1] ^ r_r[N-1]);
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
